branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer.sv | 130 +++++++++++++
 tb/tb_branch_target_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Fully associative branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational on if_pc; updates and allocations land on the rising edge.
module branch_target_buffer #(
   parameter int unsigned PC_WIDTH    = 32,
   parameter int unsigned ENTRY_COUNT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PC_WIDTH-1:0] if_pc,
   output logic                hit,
   output logic                taken_predicted,
   output logic [PC_WIDTH-1:0] target_predicted,
   input  logic                upd_valid,
   input  logic                upd_new_entry,
   input  logic [PC_WIDTH-1:0] upd_pc,
   input  logic [PC_WIDTH-1:0] upd_target,
   input  logic                upd_taken,
   input  logic                clear
);

   localparam int unsigned IdxWidth = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;

   typedef logic [IdxWidth-1:0] idx_t;

   logic [ENTRY_COUNT-1:0]      valid_q;
   logic [ENTRY_COUNT-1:0][1:0] ctr_q;
   logic [PC_WIDTH-1:0]         tag_q    [ENTRY_COUNT];
   logic [PC_WIDTH-1:0]         target_q [ENTRY_COUNT];
   idx_t                        rr_q, rr_d;

   idx_t                        hit_idx;
   logic                        upd_hit;
   idx_t                        upd_idx;
   logic                        free_found;
   idx_t                        free_idx;
   idx_t                        alloc_idx;
   logic                        do_update;
   logic                        do_alloc;
   logic [1:0]                  upd_ctr;
   logic [PC_WIDTH-1:0]         pc_plus4;

   // Descending scans so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = int'(ENTRY_COUNT) - 1; i >= 0; i--) begin
         if (valid_q[i] && (tag_q[i] == if_pc)) begin
            hit     = 1'b1;
            hit_idx = idx_t'(i);
         end
      end
   end

   always_comb begin
      upd_hit = 1'b0;
      upd_idx = '0;
      for (int i = int'(ENTRY_COUNT) - 1; i >= 0; i--) begin
         if (valid_q[i] && (tag_q[i] == upd_pc)) begin
            upd_hit = 1'b1;
            upd_idx = idx_t'(i);
         end
      end
   end

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = int'(ENTRY_COUNT) - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = idx_t'(i);
         end
      end
   end

   assign pc_plus4         = if_pc + PC_WIDTH'(4);
   assign taken_predicted  = hit & ctr_q[hit_idx][1];
   assign target_predicted = taken_predicted ? target_q[hit_idx] : pc_plus4;

   assign do_update = upd_valid & upd_hit;
   assign do_alloc  = upd_valid & upd_new_entry & ~upd_hit;
   assign alloc_idx = free_found ? free_idx : rr_q;

   always_comb begin
      upd_ctr = ctr_q[upd_idx];
      if (upd_taken) begin
         if (upd_ctr != 2'b11) upd_ctr = upd_ctr + 2'b01;
      end else begin
         if (upd_ctr != 2'b00) upd_ctr = upd_ctr - 2'b01;
      end
   end

   // The replacement pointer only moves when a live entry is evicted.
   always_comb begin
      rr_d = rr_q;
      if (do_alloc && !free_found) rr_d = rr_q + idx_t'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         ctr_q   <= '0;
         rr_q    <= '0;
      end else if (clear) begin
         valid_q <= '0;
         rr_q    <= '0;
      end else begin
         if (do_update) begin
            ctr_q[upd_idx] <= upd_ctr;
         end else if (do_alloc) begin
            valid_q[alloc_idx] <= 1'b1;
            ctr_q[alloc_idx]   <= upd_taken ? 2'b10 : 2'b01;
         end
         rr_q <= rr_d;
      end
   end

   // Tag/target payload needs no reset; entries are qualified by valid_q.
   always_ff @(posedge clk) begin
      if (!rst && !clear) begin
         if (do_update) begin
            target_q[upd_idx] <= upd_target;
         end else if (do_alloc) begin
            tag_q[alloc_idx]    <= upd_pc;
            target_q[alloc_idx] <= upd_target;
         end
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: stimulus pushes expected lookups into a
// scoreboard queue, a negedge monitor pops and compares against the DUT outputs.
module tb_branch_target_buffer;

   typedef struct packed {
      logic        hit;
      logic        taken;
      logic [31:0] target;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc;
   logic        hit;
   logic        taken_predicted;
   logic [31:0] target_predicted;
   logic        upd_valid;
   logic        upd_new_entry;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        clear;
   logic        chk_req;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks_total  = 0;
   int    checks_passed = 0;

   branch_target_buffer #(
      .PC_WIDTH    (32),
      .ENTRY_COUNT (16)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .if_pc            (if_pc),
      .hit              (hit),
      .taken_predicted  (taken_predicted),
      .target_predicted (target_predicted),
      .upd_valid        (upd_valid),
      .upd_new_entry    (upd_new_entry),
      .upd_pc           (upd_pc),
      .upd_target       (upd_target),
      .upd_taken        (upd_taken),
      .clear            (clear)
   );

   always #5 clk = ~clk;

   // Monitor: compares whenever the stimulus has flagged a lookup this cycle.
   always @(negedge clk) begin
      if (chk_req) begin
         checks_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL monitor: lookup presented with empty scoreboard");
         end else begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (hit === e.hit && taken_predicted === e.taken && target_predicted === e.target)
               checks_passed++;
            else
               $display("FAIL %s: got hit=%b taken=%b target=%h, want hit=%b taken=%b target=%h",
                        n, hit, taken_predicted, target_predicted, e.hit, e.taken, e.target);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      chk_req       = 1'b0;
      upd_valid     = 1'b0;
      upd_new_entry = 1'b0;
      clear         = 1'b0;
   endtask

   task automatic check(input logic [31:0] pc, input logic h, input logic t,
                        input logic [31:0] tgt, input string name);
      exp_t e;
      if_pc    = pc;
      e.hit    = h;
      e.taken  = t;
      e.target = tgt;
      exp_q.push_back(e);
      name_q.push_back(name);
      chk_req  = 1'b1;
   endtask

   task automatic upd(input logic new_entry, input logic [31:0] pc, input logic [31:0] tgt,
                      input logic taken);
      upd_valid     = 1'b1;
      upd_new_entry = new_entry;
      upd_pc        = pc;
      upd_target    = tgt;
      upd_taken     = taken;
   endtask

   initial begin
      rst           = 1'b1;
      if_pc         = '0;
      upd_valid     = 1'b0;
      upd_new_entry = 1'b0;
      upd_pc        = '0;
      upd_target    = '0;
      upd_taken     = 1'b0;
      clear         = 1'b0;
      chk_req       = 1'b0;
      @(posedge clk);
      #1;
      check(32'h100, 1'b0, 1'b0, 32'h104, "in_reset");
      tick();
      rst = 1'b0;
      check(32'h100, 1'b0, 1'b0, 32'h104, "post_reset_miss");
      tick();
      check(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, "pc_plus4_wrap");

      // Allocate 0x100 taken; lookup in the same cycle still sees the old contents.
      tick();
      upd(1'b1, 32'h100, 32'h200, 1'b1);
      check(32'h100, 1'b0, 1'b0, 32'h104, "alloc_same_cycle");
      tick();
      check(32'h100, 1'b1, 1'b1, 32'h200, "alloc_hit");

      // Counter walk: 2 -> 1 -> 0 -> 0, then 1, 2, 3, 3, then 2.
      tick(); upd(1'b0, 32'h100, 32'h200, 1'b0);
      tick(); check(32'h100, 1'b1, 1'b0, 32'h104, "ctr_1");
      upd(1'b0, 32'h100, 32'h200, 1'b0);
      tick(); upd(1'b0, 32'h100, 32'h200, 1'b0);
      tick(); check(32'h100, 1'b1, 1'b0, 32'h104, "ctr_sat0");
      upd(1'b0, 32'h100, 32'h200, 1'b1);
      tick(); check(32'h100, 1'b1, 1'b0, 32'h104, "ctr_up_1");
      upd(1'b0, 32'h100, 32'h200, 1'b1);
      tick(); check(32'h100, 1'b1, 1'b1, 32'h200, "ctr_up_2");
      upd(1'b0, 32'h100, 32'h200, 1'b1);
      tick(); upd(1'b0, 32'h100, 32'h200, 1'b1);
      tick(); check(32'h100, 1'b1, 1'b1, 32'h200, "ctr_sat3");
      upd(1'b0, 32'h100, 32'h200, 1'b0);
      tick(); check(32'h100, 1'b1, 1'b1, 32'h200, "ctr_3_to_2");

      // Re-allocating a present PC updates in place with the new target.
      upd(1'b1, 32'h100, 32'h300, 1'b1);
      tick(); check(32'h100, 1'b1, 1'b1, 32'h300, "realloc_target");

      // Ignored updates.
      upd(1'b1, 32'h500, 32'h900, 1'b1);
      upd_valid = 1'b0;
      tick(); check(32'h500, 1'b0, 1'b0, 32'h504, "upd_valid_low");
      upd(1'b0, 32'h600, 32'h900, 1'b1);
      tick(); check(32'h600, 1'b0, 1'b0, 32'h604, "miss_no_alloc");

      // Clear wins over a coincident allocation.
      clear = 1'b1;
      upd(1'b1, 32'h700, 32'h800, 1'b1);
      tick(); check(32'h100, 1'b0, 1'b0, 32'h104, "clear_old");
      tick(); check(32'h700, 1'b0, 1'b0, 32'h704, "clear_dropped_alloc");

      // Fill 16 entries, then 17th evicts 0x0 (rr 0 -> 1).
      for (int i = 0; i <= 16; i++) begin
         tick();
         upd(1'b1, 32'(i * 4), 32'h1000 + 32'(i * 4), 1'b1);
      end
      tick(); check(32'h0, 1'b0, 1'b0, 32'h4, "evict_0x0");
      tick(); check(32'h40, 1'b1, 1'b1, 32'h1040, "hit_0x40");
      tick(); check(32'h4, 1'b1, 1'b1, 32'h1004, "still_0x4");
      upd(1'b1, 32'h44, 32'h1044, 1'b1);
      tick(); check(32'h4, 1'b0, 1'b0, 32'h8, "evict_0x4");
      tick(); check(32'h44, 1'b1, 1'b1, 32'h1044, "hit_0x44");

      // Present-PC new_entry on a full table must not move rr (still 2).
      upd(1'b1, 32'h10, 32'h3010, 1'b0);
      tick(); check(32'h10, 1'b1, 1'b0, 32'h14, "full_realloc_nt");
      upd(1'b1, 32'h48, 32'h1048, 1'b0);
      tick(); check(32'h8, 1'b0, 1'b0, 32'hC, "evict_0x8");
      tick(); check(32'hC, 1'b1, 1'b1, 32'h100C, "keep_0xC");
      tick(); check(32'h48, 1'b1, 1'b0, 32'h4C, "alloc_nt_ctr1");

      // Asynchronous reset between edges; coincident update discarded.
      tick();
      if_pc = 32'h44;
      #2;
      rst = 1'b1;
      check(32'h44, 1'b0, 1'b0, 32'h48, "async_rst");
      upd(1'b1, 32'h900, 32'hA00, 1'b1);
      tick();
      rst = 1'b0;
      check(32'h900, 1'b0, 1'b0, 32'h904, "rst_drops_upd");
      tick(); check(32'hC, 1'b0, 1'b0, 32'h10, "rst_invalidates");
      tick();
      @(negedge clk);
      #1;
      checks_total++;
      if (exp_q.size() == 0)
         checks_passed++;
      else
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
